regfile_multibank_sb: RTL and testbench
=======================================

// Module: regfile_multibank_sb
// PURPOSE
//  Parametrised register file for the decode/writeback stages: NBANK banks (bank 0 integer, bank 1 FPU),
//  NRD independent read ports (3 for fused FP ops), one writeback port with same-cycle bypass.
//  Adds a per-register busy scoreboard (set at issue, cleared at writeback, flushable) so ID can
//  detect RAW hazards. A busy counter and a debug tap of one integer register are also provided.
// PARAMETERS
//  XLEN      32  data width
//  NREG      32  registers per bank (power of 2); AW = $clog2(NREG)
//  NBANK     2   number of banks; BW = max(1,$clog2(NBANK))
//  NRD       3   read ports
//  ZERO_IDX  {30,0}  packed NBANK*AW vector, hardwired-zero index per bank (bank0=0, bank1=30)
//  DBG_IDX   6   bank-0 register driven on dbg_reg
// PORTS
//  clk       in   1          clock, all state on rising edge
//  rst       in   1          asynchronous, active-high reset
//  rd_addr   in   NRD*AW     read addresses, port k in [k*AW +: AW]
//  rd_bank   in   NRD*BW     bank select per read port
//  rd_data   out  NRD*XLEN   read data, combinational
//  rd_busy   out  NRD        scoreboard busy flag of addressed register, combinational
//  wr_en     in   1          writeback valid
//  wr_bank   in   BW         writeback bank
//  wr_addr   in   AW         writeback register
//  wr_data   in   XLEN       writeback data
//  iss_en    in   1          instruction issued with destination (sets busy)
//  iss_bank  in   BW         issue destination bank
//  iss_addr  in   AW         issue destination register
//  flush     in   1          clear all busy bits (pipeline flush)
//  busy_cnt  out  $clog2(NBANK*NREG+1)  number of busy registers, registered
//  dbg_reg   out  XLEN       bank-0 register DBG_IDX, registered state (no bypass)
// BEHAVIOUR
//  - Reset (async, rst=1): all registers 0, all busy bits 0, busy_cnt 0; rd_data reads 0 while held.
//  - Zero register: reading ZERO_IDX of a bank returns 0, rd_busy 0; writes and issues to it are dropped.
//  - Read k: zero-reg -> 0; else wr_en & bank/addr match -> wr_data (bypass); else stored value.
//  - Write: wr_en & not zero-reg -> reg[wr_bank][wr_addr] <= wr_data on next edge; latency 1, visible same cycle via bypass.
//  - wr_bank >= NBANK or iss_bank >= NBANK: operation ignored.
//  - Scoreboard per register, priority flush > iss > wr clear:
//      flush=1 -> all busy 0 next cycle (same-cycle iss also dropped); the write still commits data.
//      iss & wr on same register -> busy stays/becomes 1 (newer producer wins).
//      wr alone -> busy 0; iss alone -> busy 1 (re-issue of busy reg keeps 1, no count change).
//  - rd_busy k: busy bit of addressed register, forced 0 if a same-cycle write clears it (bypassed);
//    a same-cycle issue is NOT reflected until next cycle.
//  - busy_cnt: incremented by +1 on 0->1 transition, -1 on 1->0, net 0 if both on different regs;
//    flush -> 0. Always equals popcount of busy bits; never wraps.
//  - dbg_reg follows stored bank-0 reg DBG_IDX, updates one cycle after write.
// STRUCTURE
//  - Package cpu_rf_pkg: BANK_INT=0, BANK_FP=1, REG_AW, XLEN default, ZERO_IDX defaults.
//  - Sub-module rf_bank (one per bank via generate): storage array, NRD read muxes with bypass,
//    write enable, zero-index masking. Scoreboard and busy_cnt live in top level.
// TESTING
//  - Reset mid-run: write int x5=0xDEAD, assert rst async mid-cycle -> rd_data(x5)=0, busy_cnt=0 immediately.
//  - Bypass: wr_en int x7=0x1234 while port1 reads int x7 -> rd_data1=0x1234 same cycle, stored next.
//  - Zero regs: write int x0=0xFFFF and fp f30=0xFFFF, issue f30 -> reads 0, rd_busy 0, busy_cnt 0.
//  - Scoreboard: issue int x3 -> next cycle rd_busy=1, busy_cnt=1; wr x3 same cycle as new issue x3
//    -> busy stays 1, count 1; wr x3 alone -> busy 0, count 0.
//  - Flush: issue 4 distinct regs over 4 cycles (busy_cnt=4), flush with iss x9 -> busy_cnt=0, x9 not busy.
//  - Bank isolation: write int x2=0xA, fp f2=0xB; 3 ports read int x2, fp f2, int x6 -> 0xA,0xB, dbg_reg value.

Source files
------------

// File: rtl/regfile_multibank_sb_pkg.sv
// -----------------------------------------------------------------------------
// cpu_rf_pkg
// Shared constants and helpers for the multi-bank register file:
//   - bank identifiers (integer / FPU)
//   - default geometry (data width, registers per bank, banks, read ports)
//   - default hardwired-zero index per bank and debug tap index
//   - bank_w()   : width of a bank-select field
//   - bank_ok()  : true when a bank number addresses an existing bank
// -----------------------------------------------------------------------------
package cpu_rf_pkg;

   localparam int BANK_INT  = 0;
   localparam int BANK_FP   = 1;

   localparam int XLEN_DEF  = 32;
   localparam int NREG_DEF  = 32;
   localparam int NBANK_DEF = 2;
   localparam int NRD_DEF   = 3;
   localparam int REG_AW    = $clog2(NREG_DEF);

   // Bank 0 hardwires x0, bank 1 hardwires f30.
   localparam int ZERO_IDX_INT = 0;
   localparam int ZERO_IDX_FP  = 30;
   localparam logic [NBANK_DEF*REG_AW-1:0] ZERO_IDX_DEF =
      {REG_AW'(ZERO_IDX_FP), REG_AW'(ZERO_IDX_INT)};

   localparam int DBG_IDX_DEF = 6;

   // A single bank still needs a 1-bit select field.
   function automatic int bank_w(input int nbank);
      return (nbank > 1) ? $clog2(nbank) : 1;
   endfunction

   // Evaluated on int arguments so out-of-range banks are caught for any NBANK.
   function automatic logic bank_ok(input int bank, input int nbank);
      return (bank < nbank) ? 1'b1 : 1'b0;
   endfunction

endpackage

// File: rtl/regfile_multibank_sb_if.sv
// -----------------------------------------------------------------------------
// regfile_multibank_sb_if
// Bus between decode/writeback logic (master) and the register file (slave).
//   rd_addr/rd_bank  -> per-port read address and bank select (packed by port)
//   rd_data/rd_busy  <- per-port read data and scoreboard busy flag
//   wr_en/wr_bank/wr_addr/wr_data -> writeback port
//   iss_en/iss_bank/iss_addr      -> issue (marks destination busy)
//   flush                         -> clears every busy bit
//   busy_cnt <- number of busy registers
//   dbg_reg  <- stored value of the bank-0 debug register
// -----------------------------------------------------------------------------
interface regfile_multibank_sb_if
   import cpu_rf_pkg::*;
#(
   parameter int XLEN  = XLEN_DEF,
   parameter int NREG  = NREG_DEF,
   parameter int NBANK = NBANK_DEF,
   parameter int NRD   = NRD_DEF
);
   localparam int AW = $clog2(NREG);
   localparam int BW = bank_w(NBANK);
   localparam int CW = $clog2(NBANK*NREG+1);

   logic [NRD*AW-1:0]   rd_addr;
   logic [NRD*BW-1:0]   rd_bank;
   logic [NRD*XLEN-1:0] rd_data;
   logic [NRD-1:0]      rd_busy;
   logic                wr_en;
   logic [BW-1:0]       wr_bank;
   logic [AW-1:0]       wr_addr;
   logic [XLEN-1:0]     wr_data;
   logic                iss_en;
   logic [BW-1:0]       iss_bank;
   logic [AW-1:0]       iss_addr;
   logic                flush;
   logic [CW-1:0]       busy_cnt;
   logic [XLEN-1:0]     dbg_reg;

   modport master (
      output rd_addr, rd_bank, wr_en, wr_bank, wr_addr, wr_data,
             iss_en, iss_bank, iss_addr, flush,
      input  rd_data, rd_busy, busy_cnt, dbg_reg
   );

   modport slave (
      input  rd_addr, rd_bank, wr_en, wr_bank, wr_addr, wr_data,
             iss_en, iss_bank, iss_addr, flush,
      output rd_data, rd_busy, busy_cnt, dbg_reg
   );

endinterface

// File: rtl/regfile_multibank_sb_rf_bank.sv
// -----------------------------------------------------------------------------
// rf_bank
// Storage for one register bank with NRD combinational read ports.
//   clk, rst  : clock, asynchronous active-high reset (clears all registers)
//   wr_en     : write strobe, already qualified for this bank by the parent
//   wr_addr   : register written
//   wr_data   : data written (also bypassed to matching reads in the same cycle)
//   rd_addr   : read addresses, port k in [k*AW +: AW]
//   rd_data   : read data, port k in [k*XLEN +: XLEN]
//   dbg_val   : stored contents of register DBG_IDX (no bypass)
// The ZERO_IDX register is never written and always reads 0.
// -----------------------------------------------------------------------------
module rf_bank
   import cpu_rf_pkg::*;
#(
   parameter int XLEN     = XLEN_DEF,
   parameter int NREG     = NREG_DEF,
   parameter int NRD      = NRD_DEF,
   parameter int ZERO_IDX = ZERO_IDX_INT,
   parameter int DBG_IDX  = DBG_IDX_DEF
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          wr_en,
   input  logic [$clog2(NREG)-1:0]       wr_addr,
   input  logic [XLEN-1:0]               wr_data,
   input  logic [NRD*$clog2(NREG)-1:0]   rd_addr,
   output logic [NRD*XLEN-1:0]           rd_data,
   output logic [XLEN-1:0]               dbg_val
);
   localparam int AW = $clog2(NREG);
   localparam logic [AW-1:0] ZERO_A = AW'(ZERO_IDX);
   localparam logic [AW-1:0] DBG_A  = AW'(DBG_IDX);

   logic [XLEN-1:0] mem_q [NREG];
   logic [XLEN-1:0] mem_d [NREG];

   // Next-state of the storage array: one register updated per write.
   always_comb begin
      mem_d = mem_q;
      if (wr_en && (wr_addr != ZERO_A)) begin
         mem_d[wr_addr] = wr_data;
      end else begin
         mem_d = mem_q;
      end
   end

   // Storage array register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         mem_q <= mem_d;
      end
   end

   // Read muxes: zero register first, then same-cycle write bypass, then storage.
   always_comb begin
      rd_data = '0;
      for (int k = 0; k < NRD; k++) begin
         if (rd_addr[k*AW +: AW] == ZERO_A) begin
            rd_data[k*XLEN +: XLEN] = '0;
         end else if (wr_en && (wr_addr == rd_addr[k*AW +: AW])) begin
            rd_data[k*XLEN +: XLEN] = wr_data;
         end else begin
            rd_data[k*XLEN +: XLEN] = mem_q[rd_addr[k*AW +: AW]];
         end
      end
   end

   assign dbg_val = mem_q[DBG_A];

endmodule

// File: rtl/regfile_multibank_sb.sv
// -----------------------------------------------------------------------------
// regfile_multibank_sb
// Multi-bank register file with writeback bypass and a per-register busy
// scoreboard used by decode for RAW hazard detection.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of regfile_multibank_sb_if
//              reads  : rd_addr/rd_bank -> rd_data/rd_busy (combinational)
//              write  : wr_en/wr_bank/wr_addr/wr_data (commits next edge)
//              issue  : iss_en/iss_bank/iss_addr (sets busy next edge)
//              flush  : clears all busy bits next edge
//              status : busy_cnt (registered), dbg_reg (bank-0 DBG_IDX)
// Storage lives in one rf_bank per bank; scoreboard and counter live here.
// -----------------------------------------------------------------------------
module regfile_multibank_sb
   import cpu_rf_pkg::*;
#(
   parameter int XLEN  = XLEN_DEF,
   parameter int NREG  = NREG_DEF,
   parameter int NBANK = NBANK_DEF,
   parameter int NRD   = NRD_DEF,
   parameter logic [NBANK*$clog2(NREG)-1:0] ZERO_IDX = ZERO_IDX_DEF,
   parameter int DBG_IDX = DBG_IDX_DEF
) (
   input  logic                    clk,
   input  logic                    rst,
   regfile_multibank_sb_if.slave   bus
);
   localparam int AW  = $clog2(NREG);
   localparam int BW  = bank_w(NBANK);
   localparam int NSB = NBANK*NREG;
   localparam int IW  = BW + AW;
   localparam int CW  = $clog2(NSB+1);

   // True when (b, a) names the hardwired-zero register of an existing bank.
   function automatic logic is_zero(input logic [BW-1:0] b, input logic [AW-1:0] a);
      logic r;
      r = 1'b0;
      for (int i = 0; i < NBANK; i++) begin
         r = r | ((int'(b) == i) && (a == ZERO_IDX[i*AW +: AW]));
      end
      return r;
   endfunction

   logic                 wr_v_s;
   logic                 iss_v_s;
   logic [IW-1:0]        wr_idx_s;
   logic [IW-1:0]        iss_idx_s;
   logic [NBANK-1:0]     bank_we_s;
   logic [NRD*XLEN-1:0]  bank_rd_s [NBANK];
   logic [XLEN-1:0]      dbg_s     [NBANK];
   logic [NRD*XLEN-1:0]  rd_data_s;
   logic [NRD-1:0]       rd_busy_s;
   logic [NSB-1:0]       busy_q;
   logic [NSB-1:0]       busy_d;
   logic [CW-1:0]        cnt_q;
   logic [CW-1:0]        cnt_d;
   logic                 inc_s;
   logic                 dec_s;

   // Qualify write and issue: valid bank, not the zero register, not in reset.
   always_comb begin
      wr_v_s    = bus.wr_en & ~rst & bank_ok(int'(bus.wr_bank), NBANK)
                  & ~is_zero(bus.wr_bank, bus.wr_addr);
      iss_v_s   = bus.iss_en & ~rst & bank_ok(int'(bus.iss_bank), NBANK)
                  & ~is_zero(bus.iss_bank, bus.iss_addr);
      wr_idx_s  = {bus.wr_bank, bus.wr_addr};
      iss_idx_s = {bus.iss_bank, bus.iss_addr};
   end

   // Steer the qualified write strobe to its bank.
   always_comb begin
      bank_we_s = '0;
      for (int b = 0; b < NBANK; b++) begin
         bank_we_s[b] = wr_v_s && (int'(bus.wr_bank) == b);
      end
   end

   for (genvar gb = 0; gb < NBANK; gb++) begin : g_bank
      rf_bank #(
         .XLEN     (XLEN),
         .NREG     (NREG),
         .NRD      (NRD),
         .ZERO_IDX (int'(ZERO_IDX[gb*AW +: AW])),
         .DBG_IDX  (DBG_IDX)
      ) u_bank (
         .clk      (clk),
         .rst      (rst),
         .wr_en    (bank_we_s[gb]),
         .wr_addr  (bus.wr_addr),
         .wr_data  (bus.wr_data),
         .rd_addr  (bus.rd_addr),
         .rd_data  (bank_rd_s[gb]),
         .dbg_val  (dbg_s[gb])
      );
   end

   // Per-port bank select for data; busy flag hides a bit the same-cycle write clears.
   always_comb begin
      rd_data_s = '0;
      rd_busy_s = '0;
      for (int k = 0; k < NRD; k++) begin
         if (bank_ok(int'(bus.rd_bank[k*BW +: BW]), NBANK)) begin
            rd_data_s[k*XLEN +: XLEN] = bank_rd_s[bus.rd_bank[k*BW +: BW]][k*XLEN +: XLEN];
            if (is_zero(bus.rd_bank[k*BW +: BW], bus.rd_addr[k*AW +: AW])) begin
               rd_busy_s[k] = 1'b0;
            end else if (wr_v_s &&
                         (wr_idx_s == {bus.rd_bank[k*BW +: BW], bus.rd_addr[k*AW +: AW]})) begin
               rd_busy_s[k] = 1'b0;
            end else begin
               rd_busy_s[k] = busy_q[{bus.rd_bank[k*BW +: BW], bus.rd_addr[k*AW +: AW]}];
            end
         end else begin
            rd_data_s[k*XLEN +: XLEN] = '0;
            rd_busy_s[k]              = 1'b0;
         end
      end
   end

   // Scoreboard next state: flush beats issue, issue beats writeback clear.
   always_comb begin
      busy_d = busy_q;
      cnt_d  = cnt_q;
      inc_s  = 1'b0;
      dec_s  = 1'b0;
      if (bus.flush) begin
         busy_d = '0;
         cnt_d  = '0;
      end else begin
         // Count only real transitions so busy_cnt tracks the popcount exactly.
         inc_s = iss_v_s && !busy_q[iss_idx_s];
         dec_s = wr_v_s && busy_q[wr_idx_s] && !(iss_v_s && (iss_idx_s == wr_idx_s));
         if (wr_v_s) begin
            busy_d[wr_idx_s] = 1'b0;
         end else begin
            busy_d = busy_d;
         end
         if (iss_v_s) begin
            busy_d[iss_idx_s] = 1'b1;
         end else begin
            busy_d = busy_d;
         end
         cnt_d = cnt_q + CW'(inc_s) - CW'(dec_s);
      end
   end

   // Scoreboard bits and busy counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_q <= '0;
         cnt_q  <= '0;
      end else begin
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
      end
   end

   assign bus.rd_data  = rd_data_s;
   assign bus.rd_busy  = rd_busy_s;
   assign bus.busy_cnt = cnt_q;
   assign bus.dbg_reg  = dbg_s[BANK_INT];

endmodule

// File: tb/tb_regfile_multibank_sb.sv
// -----------------------------------------------------------------------------
// tb_regfile_multibank_sb
// Directed bench for regfile_multibank_sb: reset, bypass, zero registers,
// scoreboard set/clear/priority, flush, bank isolation, debug tap and an
// asynchronous reset in the middle of a run.
// -----------------------------------------------------------------------------
module tb_regfile_multibank_sb;
   import cpu_rf_pkg::*;

   localparam int XLEN  = 32;
   localparam int NREG  = 32;
   localparam int NBANK = 2;
   localparam int NRD   = 3;
   localparam int AW    = 5;

   logic clk;
   logic rst;
   int   n_chk  = 0;
   int   n_pass = 0;

   regfile_multibank_sb_if #(.XLEN(XLEN), .NREG(NREG), .NBANK(NBANK), .NRD(NRD)) bus ();

   regfile_multibank_sb #(
      .XLEN     (XLEN),
      .NREG     (NREG),
      .NBANK    (NBANK),
      .NRD      (NRD),
      .ZERO_IDX ({5'd30, 5'd0}),
      .DBG_IDX  (6)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] rdd(input int k);
      return bus.rd_data[k*XLEN +: XLEN];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ctl_off();
      bus.wr_en  = 1'b0;
      bus.iss_en = 1'b0;
      bus.flush  = 1'b0;
   endtask

   task automatic set_rd(input int k, input logic b, input logic [4:0] a);
      bus.rd_bank[k]          = b;
      bus.rd_addr[k*AW +: AW] = a;
   endtask

   task automatic wr(input logic b, input logic [4:0] a, input logic [31:0] d);
      bus.wr_en   = 1'b1;
      bus.wr_bank = b;
      bus.wr_addr = a;
      bus.wr_data = d;
   endtask

   task automatic iss(input logic b, input logic [4:0] a);
      bus.iss_en   = 1'b1;
      bus.iss_bank = b;
      bus.iss_addr = a;
   endtask

   initial begin
      rst          = 1'b1;
      bus.rd_addr  = '0;
      bus.rd_bank  = '0;
      bus.wr_bank  = 1'b0;
      bus.wr_addr  = 5'd0;
      bus.wr_data  = 32'd0;
      bus.iss_bank = 1'b0;
      bus.iss_addr = 5'd0;
      ctl_off();
      set_rd(0, 1'b0, 5'd5);
      #2;
      chk("rst_rd", 64'(rdd(0)), 64'h0);
      chk("rst_cnt", 64'(bus.busy_cnt), 64'h0);
      chk("rst_dbg", 64'(bus.dbg_reg), 64'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Bypass: int x7 written while port 1 reads it
      wr(1'b0, 5'd7, 32'h1234);
      set_rd(1, 1'b0, 5'd7);
      #1 chk("byp_same", 64'(rdd(1)), 64'h1234);
      tick(); ctl_off();
      #1 chk("byp_stored", 64'(rdd(1)), 64'h1234);

      // Zero registers: int x0 and fp f30
      wr(1'b0, 5'd0, 32'hFFFF);
      set_rd(0, 1'b0, 5'd0);
      #1 chk("zero_int_byp", 64'(rdd(0)), 64'h0);
      tick();
      wr(1'b1, 5'd30, 32'hFFFF);
      iss(1'b1, 5'd30);
      set_rd(1, 1'b1, 5'd30);
      #1 chk("zero_fp_byp", 64'(rdd(1)), 64'h0);
      tick(); ctl_off();
      #1;
      chk("zero_int", 64'(rdd(0)), 64'h0);
      chk("zero_fp", 64'(rdd(1)), 64'h0);
      chk("zero_fp_busy", 64'(bus.rd_busy[1]), 64'h0);
      chk("zero_cnt", 64'(bus.busy_cnt), 64'h0);

      // Scoreboard on int x3
      iss(1'b0, 5'd3);
      set_rd(2, 1'b0, 5'd3);
      #1 chk("sb_iss_same", 64'(bus.rd_busy[2]), 64'h0);
      tick(); ctl_off();
      #1;
      chk("sb_busy1", 64'(bus.rd_busy[2]), 64'h1);
      chk("sb_cnt1", 64'(bus.busy_cnt), 64'h1);
      wr(1'b0, 5'd3, 32'h33);
      iss(1'b0, 5'd3);
      #1 chk("sb_wr_iss_byp", 64'(bus.rd_busy[2]), 64'h0);
      tick(); ctl_off();
      #1;
      chk("sb_reiss_busy", 64'(bus.rd_busy[2]), 64'h1);
      chk("sb_reiss_cnt", 64'(bus.busy_cnt), 64'h1);
      wr(1'b0, 5'd3, 32'h44);
      #1 chk("sb_wr_byp", 64'(bus.rd_busy[2]), 64'h0);
      tick(); ctl_off();
      #1;
      chk("sb_clr_busy", 64'(bus.rd_busy[2]), 64'h0);
      chk("sb_clr_cnt", 64'(bus.busy_cnt), 64'h0);
      chk("sb_clr_data", 64'(rdd(2)), 64'h44);

      // Issue one register while writeback clears another: net count change 0
      iss(1'b0, 5'd13);
      tick(); ctl_off();
      #1 chk("net_cnt_a", 64'(bus.busy_cnt), 64'h1);
      iss(1'b0, 5'd14);
      wr(1'b0, 5'd13, 32'h5);
      tick(); ctl_off();
      set_rd(0, 1'b0, 5'd13);
      set_rd(1, 1'b0, 5'd14);
      #1;
      chk("net_cnt_b", 64'(bus.busy_cnt), 64'h1);
      chk("net_busy13", 64'(bus.rd_busy[0]), 64'h0);
      chk("net_busy14", 64'(bus.rd_busy[1]), 64'h1);
      iss(1'b0, 5'd14);
      tick(); ctl_off();
      #1 chk("reiss_cnt", 64'(bus.busy_cnt), 64'h1);
      wr(1'b0, 5'd14, 32'h0);
      tick(); ctl_off();
      #1 chk("net_cnt_c", 64'(bus.busy_cnt), 64'h0);

      // Flush after four distinct issues; same-cycle issue dropped, write kept
      iss(1'b0, 5'd10); tick();
      iss(1'b0, 5'd11); tick();
      iss(1'b1, 5'd4);  tick();
      iss(1'b0, 5'd12); tick();
      ctl_off();
      #1 chk("fl_cnt4", 64'(bus.busy_cnt), 64'h4);
      set_rd(0, 1'b0, 5'd9);
      bus.flush = 1'b1;
      iss(1'b0, 5'd9);
      wr(1'b0, 5'd9, 32'h99);
      tick(); ctl_off();
      #1;
      chk("fl_cnt0", 64'(bus.busy_cnt), 64'h0);
      chk("fl_x9_busy", 64'(bus.rd_busy[0]), 64'h0);
      chk("fl_x9_data", 64'(rdd(0)), 64'h99);

      // Debug tap (no bypass) and bank isolation
      wr(1'b0, 5'd6, 32'hC0FFEE);
      #1 chk("dbg_nobyp", 64'(bus.dbg_reg), 64'h0);
      tick(); ctl_off();
      #1 chk("dbg_upd", 64'(bus.dbg_reg), 64'hC0FFEE);
      wr(1'b0, 5'd2, 32'hA); tick();
      wr(1'b1, 5'd2, 32'hB); tick();
      ctl_off();
      set_rd(0, 1'b0, 5'd2);
      set_rd(1, 1'b1, 5'd2);
      set_rd(2, 1'b0, 5'd6);
      #1;
      chk("iso_int_x2", 64'(rdd(0)), 64'hA);
      chk("iso_fp_f2", 64'(rdd(1)), 64'hB);
      chk("iso_int_x6", 64'(rdd(2)), 64'hC0FFEE);

      // Asynchronous reset in the middle of a cycle
      wr(1'b0, 5'd5, 32'hDEAD); tick(); ctl_off();
      iss(1'b0, 5'd8); tick(); ctl_off();
      set_rd(0, 1'b0, 5'd5);
      #1;
      chk("pre_rst_x5", 64'(rdd(0)), 64'hDEAD);
      chk("pre_rst_cnt", 64'(bus.busy_cnt), 64'h1);
      #1 rst = 1'b1;
      #1;
      chk("mid_rst_x5", 64'(rdd(0)), 64'h0);
      chk("mid_rst_f2", 64'(rdd(1)), 64'h0);
      chk("mid_rst_cnt", 64'(bus.busy_cnt), 64'h0);
      chk("mid_rst_dbg", 64'(bus.dbg_reg), 64'h0);
      tick();
      rst = 1'b0;
      tick();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
